hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Purpose : groups the decode / AGEX / writeback signals that talk to the
//           register hazard scoreboard into one bundle.
// Modports:
//   master - pipeline side: drives issue_valid, issue_wr_reg, issue_wregno,
//            src_rs, src_rt, use_rt, issue_ctrl, br_resolved, wb_valid,
//            wb_wregno; observes data_hazard, control_hazard, issue_fire,
//            pending_mask, sb_error.
//   slave  - scoreboard side: the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int NREGS     = 16,
    parameter int REGNOBITS = 4
);
    logic                 issue_valid;
    logic                 issue_wr_reg;
    logic [REGNOBITS-1:0] issue_wregno;
    logic [REGNOBITS-1:0] src_rs;
    logic [REGNOBITS-1:0] src_rt;
    logic                 use_rt;
    logic                 issue_ctrl;
    logic                 br_resolved;
    logic                 wb_valid;
    logic [REGNOBITS-1:0] wb_wregno;
    logic                 data_hazard;
    logic                 control_hazard;
    logic                 issue_fire;
    logic [NREGS-1:0]     pending_mask;
    logic                 sb_error;

    modport master (
        output issue_valid, issue_wr_reg, issue_wregno, src_rs, src_rt,
               use_rt, issue_ctrl, br_resolved, wb_valid, wb_wregno,
        input  data_hazard, control_hazard, issue_fire, pending_mask, sb_error
    );

    modport slave (
        input  issue_valid, issue_wr_reg, issue_wregno, src_rs, src_rt,
               use_rt, issue_ctrl, br_resolved, wb_valid, wb_wregno,
        output data_hazard, control_hazard, issue_fire, pending_mask, sb_error
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Purpose : tracks outstanding register writes with one small pending
//           counter per architectural register, stalls decode on operand
//           dependences or a full counter, and stalls fetch while a branch
//           or JAL is unresolved.
// Ports   :
//   clk    - single clock, all state changes on its rising edge
//   reset  - synchronous active-high reset (clears counters, FSM, error)
//   bus    - hazard_scoreboard_if.slave: issue/source/writeback inputs,
//            data_hazard / control_hazard / issue_fire / pending_mask /
//            sb_error outputs
// Config  : define SCOREBOARD_WB_BYPASS_EN to let a source whose only
//           pending write retires this cycle issue without stalling.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREGS     = 16,
    parameter int REGNOBITS = 4,
    parameter int CNTBITS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    localparam logic [CNTBITS-1:0] CNT_MAX = '1;
    localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

    typedef enum logic {
        IDLE,
        BR_WAIT
    } ctrlState_t;

    ctrlState_t           r_state;
    logic [CNTBITS-1:0]   r_cnt [NREGS];
    logic                 r_sbError;

    logic                 w_rsBypass;
    logic                 w_rtBypass;
    logic                 w_rsBusy;
    logic                 w_rtBusy;
    logic                 w_dstFull;
    logic                 w_dataHazard;
    logic                 w_issueFire;
    logic                 w_incEn;
    logic                 w_sameReg;
    logic                 w_underflow;
    logic                 w_overflow;
    logic [NREGS-1:0]     w_incHit;
    logic [NREGS-1:0]     w_decHit;
    logic [NREGS-1:0]     w_pendingMask;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // A source whose single outstanding write is retiring right now can read
    // the forwarded writeback value, so it does not need to stall.
    assign w_rsBypass = bus.wb_valid && (bus.wb_wregno == bus.src_rs) &&
                        (r_cnt[bus.src_rs] == CNT_ONE);
    assign w_rtBypass = bus.wb_valid && (bus.wb_wregno == bus.src_rt) &&
                        (r_cnt[bus.src_rt] == CNT_ONE);
`else
    assign w_rsBypass = 1'b0;
    assign w_rtBypass = 1'b0;
`endif

    assign w_rsBusy     = (r_cnt[bus.src_rs] != '0) && !w_rsBypass;
    assign w_rtBusy     = bus.use_rt && (r_cnt[bus.src_rt] != '0) && !w_rtBypass;
    // A destination counter at its maximum cannot absorb another write.
    assign w_dstFull    = bus.issue_wr_reg && (r_cnt[bus.issue_wregno] == CNT_MAX);
    assign w_dataHazard = bus.issue_valid && (w_rsBusy || w_rtBusy || w_dstFull);
    assign w_issueFire  = bus.issue_valid && !w_dataHazard && (r_state == IDLE);
    assign w_incEn      = w_issueFire && bus.issue_wr_reg;

    // Same-register increment and decrement cancel, so neither can flag an
    // error in that case.
    assign w_sameReg    = w_incEn && bus.wb_valid && (bus.issue_wregno == bus.wb_wregno);
    assign w_underflow  = bus.wb_valid && (r_cnt[bus.wb_wregno] == '0) && !w_sameReg;
    assign w_overflow   = w_incEn && (r_cnt[bus.issue_wregno] == CNT_MAX) && !w_sameReg;

    // Decode the issue and writeback register numbers into per-register
    // hit vectors and collapse each counter into its pending bit.
    always_comb begin
        w_incHit      = '0;
        w_decHit      = '0;
        w_pendingMask = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_incHit[i]      = w_incEn && (bus.issue_wregno == REGNOBITS'(i));
            w_decHit[i]      = bus.wb_valid && (bus.wb_wregno == REGNOBITS'(i));
            w_pendingMask[i] = (r_cnt[i] != '0);
        end
    end

    // Pending counters and the sticky error flag. Counters saturate at both
    // ends; an out-of-range update is dropped and recorded in sb_error.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_sbError <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_incHit[i] && !w_decHit[i]) begin
                    if (r_cnt[i] != CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end else if (w_decHit[i] && !w_incHit[i]) begin
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - CNT_ONE;
                    end
                end
            end
            if (w_underflow || w_overflow) begin
                r_sbError <= 1'b1;
            end
        end
    end

    // Control FSM: once a branch/JAL issues, hold everything until AGEX
    // reports it resolved. A stray br_resolved while idle is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issueFire && bus.issue_ctrl) begin
                        r_state <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (bus.br_resolved) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data_hazard    = w_dataHazard;
    assign bus.issue_fire     = w_issueFire;
    assign bus.control_hazard = (r_state == BR_WAIT) || (bus.issue_valid && bus.issue_ctrl);
    assign bus.pending_mask   = w_pendingMask;
    assign bus.sb_error       = r_sbError;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Purpose : directed self-checking bench for hazard_scoreboard. Each step
//           drives one cycle of inputs, queues the outputs expected for that
//           cycle, and compares them before the next rising edge.
// Config  : expectations follow SCOREBOARD_WB_BYPASS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic        dh;
        logic        ch;
        logic        fire;
        logic [15:0] mask;
        logic        err;
    } expect_t;

    logic    clk;
    logic    reset;
    int      checkCount;
    int      errorCount;
    expect_t expQ [$];

    hazard_scoreboard_if #(.NREGS(16), .REGNOBITS(4)) tbBus ();

    hazard_scoreboard #(
        .NREGS    (16),
        .REGNOBITS(4),
        .CNTBITS  (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tbBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on a miss reports tag/observed/expected.
    task automatic checkVal(input string tag, input string what,
                            input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp)
        else begin
            errorCount++;
            $error("[TB] FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic checkOutput();
        expect_t e;
        if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = expQ.pop_front();
        checkVal(e.tag, "data_hazard",    32'(tbBus.data_hazard),    32'(e.dh));
        checkVal(e.tag, "control_hazard", 32'(tbBus.control_hazard), 32'(e.ch));
        checkVal(e.tag, "issue_fire",     32'(tbBus.issue_fire),     32'(e.fire));
        checkVal(e.tag, "pending_mask",   32'(tbBus.pending_mask),   32'(e.mask));
        checkVal(e.tag, "sb_error",       32'(tbBus.sb_error),       32'(e.err));
    endtask

    // Drive one cycle of inputs, queue the expected outputs, check them
    // mid-cycle and then step past the next rising edge.
    task automatic applyStimulus(
        input string tag,
        input logic  rst,
        input logic  v,  input logic wr, input int wreg,
        input int    rs, input int rt,   input logic useRt,
        input logic  ctrl, input logic brRes,
        input logic  wbV, input int wbReg,
        input logic  eDh, input logic eCh, input logic eFire,
        input logic [15:0] eMask, input logic eErr
    );
        expect_t e;
        reset                = rst;
        tbBus.issue_valid    = v;
        tbBus.issue_wr_reg   = wr;
        tbBus.issue_wregno   = 4'(wreg);
        tbBus.src_rs         = 4'(rs);
        tbBus.src_rt         = 4'(rt);
        tbBus.use_rt         = useRt;
        tbBus.issue_ctrl     = ctrl;
        tbBus.br_resolved    = brRes;
        tbBus.wb_valid       = wbV;
        tbBus.wb_wregno      = 4'(wbReg);
        e.tag  = tag;
        e.dh   = eDh;
        e.ch   = eCh;
        e.fire = eFire;
        e.mask = eMask;
        e.err  = eErr;
        expQ.push_back(e);
        #2;
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset                = 1'b1;
        tbBus.issue_valid    = 1'b0;
        tbBus.issue_wr_reg   = 1'b0;
        tbBus.issue_wregno   = '0;
        tbBus.src_rs         = '0;
        tbBus.src_rt         = '0;
        tbBus.use_rt         = 1'b0;
        tbBus.issue_ctrl     = 1'b0;
        tbBus.br_resolved    = 1'b0;
        tbBus.wb_valid       = 1'b0;
        tbBus.wb_wregno      = '0;
        repeat (2) @(posedge clk);
        #1;

        //            tag             rst v wr wr#  rs rt uRt ctl br wb wb#  dh ch fi mask     err
        applyStimulus("reset_hold",    1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        // Dependence on r3 stalls until r3 retires.
        applyStimulus("r3_issue",      0, 1, 1, 3,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("r3_dep",        0, 1, 1, 4,  3, 0, 0,  0,  0, 0, 0,  1, 0, 0, 16'h0008, 0);
        applyStimulus("r3_dep_hold",   0, 1, 1, 4,  3, 0, 0,  0,  0, 0, 0,  1, 0, 0, 16'h0008, 0);
        applyStimulus("rt_unused",     0, 1, 0, 0,  0, 3, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0008, 0);
        applyStimulus("rt_used",       0, 1, 0, 0,  0, 3, 1,  0,  0, 0, 0,  1, 0, 0, 16'h0008, 0);
        applyStimulus("r3_wb",         0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 3,  0, 0, 0, 16'h0008, 0);
        applyStimulus("r3_release",    0, 1, 1, 4,  3, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("r4_wb",         0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 4,  0, 0, 0, 16'h0010, 0);

        // Fill r5 to the counter maximum, then a fourth write must stall.
        applyStimulus("r5_w1",         0, 1, 1, 5,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("r5_w2",         0, 1, 1, 5,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0020, 0);
        applyStimulus("r5_w3",         0, 1, 1, 5,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0020, 0);
        applyStimulus("r5_full",       0, 1, 1, 5,  0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 16'h0020, 0);
        applyStimulus("r5_wb1",        0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 5,  0, 0, 0, 16'h0020, 0);
        applyStimulus("r5_wb2",        0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 5,  0, 0, 0, 16'h0020, 0);
        applyStimulus("r5_wb3",        0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 5,  0, 0, 0, 16'h0020, 0);
        applyStimulus("r5_clear",      0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        // Simultaneous issue and writeback of r7 leave its count at 1.
        applyStimulus("r7_w",          0, 1, 1, 7,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("r7_w_wb",       0, 1, 1, 7,  0, 0, 0,  0,  0, 1, 7,  0, 0, 1, 16'h0080, 0);
        applyStimulus("r7_held",       0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 7,  0, 0, 0, 16'h0080, 0);
        applyStimulus("r7_clear",      0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        // Underflow on r9 sets a sticky error that only reset clears.
        applyStimulus("r9_underflow",  0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 9,  0, 0, 0, 16'h0000, 0);
        applyStimulus("err_sticky1",   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 1);
        applyStimulus("err_sticky2",   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 1);
        applyStimulus("err_reset",     1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 1);
        applyStimulus("err_cleared",   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        // Branch blocks the next ALU issue until resolved.
        applyStimulus("br_issue",      0, 1, 0, 0,  0, 0, 1,  1,  0, 0, 0,  0, 1, 1, 16'h0000, 0);
        applyStimulus("br_block",      0, 1, 1, 1,  0, 0, 0,  0,  0, 0, 0,  0, 1, 0, 16'h0000, 0);
        applyStimulus("br_resolve",    0, 1, 1, 1,  0, 0, 0,  0,  1, 0, 0,  0, 1, 0, 16'h0000, 0);
        applyStimulus("br_after",      0, 1, 1, 1,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("r1_wb",         0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 1,  0, 0, 0, 16'h0002, 0);
        applyStimulus("br_res_idle",   0, 0, 0, 0,  0, 0, 0,  0,  1, 0, 0,  0, 0, 0, 16'h0000, 0);
        applyStimulus("idle_after_br", 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        // Reset wins over BR_WAIT and over a simultaneous issue.
        applyStimulus("br_issue2",     0, 1, 0, 0,  0, 0, 1,  1,  0, 0, 0,  0, 1, 1, 16'h0000, 0);
        applyStimulus("rst_in_brwait", 1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 1, 0, 16'h0000, 0);
        applyStimulus("rst_held",      1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);
        applyStimulus("post_rst_issue",0, 1, 1, 1,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("rst_with_issue",1, 1, 1, 2,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0002, 0);
        applyStimulus("rst_cleared",   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        // Same-cycle writeback of the only pending r2 write.
        applyStimulus("r2_w",          0, 1, 1, 2,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("bypass",        0, 1, 0, 0,  2, 0, 0,  0,  0, 1, 2,  !BYP, 0, BYP, 16'h0004, 0);
        applyStimulus("bypass_after",  0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        // Register 0 is tracked like any other register.
        applyStimulus("r0_w",          0, 1, 1, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 1, 16'h0000, 0);
        applyStimulus("r0_dep",        0, 1, 0, 0,  0, 0, 0,  0,  0, 0, 0,  1, 0, 0, 16'h0001, 0);
        applyStimulus("r0_wb",         0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 0,  0, 0, 0, 16'h0001, 0);
        applyStimulus("r0_clear",      0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 16'h0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
